// File: rtl/multicycle_ctrl_seq.sv
// Multicycle control sequencer for the MIPS-subset datapath: Moore FSM with
// configurable memory wait states, counted mult/div phase and exception entry.
module multicycle_ctrl_seq #(
  parameter int          MEM_LAT   = 2,
  parameter int          MD_CYCLES = 32,
  parameter logic [7:0]  VEC_BASE  = 8'd253
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       div0,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic [1:0] mem_addr_sel,
  output logic [7:0] vec_addr,
  output logic [2:0] alu_op,
  output logic       alu_src_b,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       sp_init,
  output logic       md_start,
  output logic       hi_lo_write,
  output logic       epc_write,
  output logic [1:0] exc_cause,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXEC_ALU, S_WB_ALU,
    S_MEM_ADDR, S_MEM_ST, S_MEM_WAIT, S_MEM_WB, S_MD_RUN, S_MD_WB,
    S_JUMP, S_EXC_EPC, S_EXC_VEC_WAIT, S_EXC_LOAD_PC
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_write;
    logic [1:0] mem_addr_sel;
    logic [7:0] vec_addr;
    logic [2:0] alu_op;
    logic       alu_src_b;
    logic       reg_write;
    logic       mem_to_reg;
    logic       sp_init;
    logic       md_start;
    logic       hi_lo_write;
    logic       epc_write;
    logic [1:0] exc_cause;
    logic [3:0] state;
  } ctrl_t;

  localparam logic [5:0] LAT_M1 = 6'(MEM_LAT - 1);
  localparam logic [5:0] MD_M1  = 6'(MD_CYCLES - 1);

  state_t     r_state, w_next;
  logic [5:0] r_cnt;
  logic [1:0] r_cause, w_cause_nxt;
  logic       w_last;
  ctrl_t      w_c, w_g;

  // Instruction decode straight from IR fields; IR is stable from DECODE on.
  logic w_rtype, w_add, w_sub, w_and, w_mult, w_div, w_jr;
  logic w_j, w_addi, w_lw, w_sw;
  logic [2:0] w_alu_op;

  assign w_rtype = (opcode == 6'h00);
  assign w_add   = w_rtype && (funct == 6'h20);
  assign w_sub   = w_rtype && (funct == 6'h22);
  assign w_and   = w_rtype && (funct == 6'h24);
  assign w_mult  = w_rtype && (funct == 6'h18);
  assign w_div   = w_rtype && (funct == 6'h1A);
  assign w_jr    = w_rtype && (funct == 6'h08);
  assign w_j     = (opcode == 6'h02);
  assign w_addi  = (opcode == 6'h08);
  assign w_lw    = (opcode == 6'h23);
  assign w_sw    = (opcode == 6'h2B);
  assign w_alu_op = (w_add || w_addi) ? 3'd1 : w_sub ? 3'd2 : w_and ? 3'd3 : 3'd0;

  assign w_last = (r_state == S_MD_RUN) ? (r_cnt == MD_M1) : (r_cnt == LAT_M1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
      r_cause <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause_nxt;
      // Counter restarts from zero whenever a new state is entered.
      r_cnt   <= (w_next == r_state) ? r_cnt + 6'd1 : '0;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_cause_nxt = r_cause;
    case (r_state)
      S_RESET:      w_next = S_FETCH;
      S_FETCH:      w_next = S_FETCH_WAIT;
      S_FETCH_WAIT: if (w_last) w_next = S_DECODE;
      S_DECODE: begin
        if (w_add || w_sub || w_and || w_addi) w_next = S_EXEC_ALU;
        else if (w_mult || w_div)              w_next = S_MD_RUN;
        else if (w_jr || w_j)                  w_next = S_JUMP;
        else if (w_lw || w_sw)                 w_next = S_MEM_ADDR;
        else begin
          w_next      = S_EXC_EPC;
          w_cause_nxt = 2'd0;
        end
      end
      S_EXEC_ALU: begin
        if (overflow && (w_add || w_sub || w_addi)) begin
          w_next      = S_EXC_EPC;
          w_cause_nxt = 2'd1;
        end else begin
          w_next = S_WB_ALU;
        end
      end
      S_WB_ALU:   w_next = S_FETCH;
      S_MEM_ADDR: w_next = w_sw ? S_MEM_ST : S_MEM_WAIT;
      S_MEM_ST:   w_next = S_FETCH;
      S_MEM_WAIT: if (w_last) w_next = S_MEM_WB;
      S_MEM_WB:   w_next = S_FETCH;
      S_MD_RUN: begin
        // div0 is only meaningful in the first iteration cycle.
        if ((r_cnt == 6'd0) && w_div && div0) begin
          w_next      = S_EXC_EPC;
          w_cause_nxt = 2'd2;
        end else if (w_last) begin
          w_next = S_MD_WB;
        end
      end
      S_MD_WB:        w_next = S_FETCH;
      S_JUMP:         w_next = S_FETCH;
      S_EXC_EPC:      w_next = S_EXC_VEC_WAIT;
      S_EXC_VEC_WAIT: if (w_last) w_next = S_EXC_LOAD_PC;
      S_EXC_LOAD_PC:  w_next = S_FETCH;
      default:        w_next = S_RESET;
    endcase
  end

  always_comb begin
    w_c           = '0;
    w_c.exc_cause = r_cause;
    w_c.state     = r_state;
    case (r_state)
      S_RESET:      begin w_c.reg_write = 1'b1; w_c.sp_init = 1'b1; end
      S_FETCH:      begin w_c.pc_write = 1'b1; w_c.alu_op = 3'd1; w_c.alu_src_b = 1'b1; end
      S_FETCH_WAIT: w_c.ir_write = w_last;
      S_EXEC_ALU:   begin w_c.alu_op = w_alu_op; w_c.alu_src_b = w_addi; end
      S_WB_ALU:     w_c.reg_write = 1'b1;
      S_MEM_ADDR:   begin w_c.alu_op = 3'd1; w_c.alu_src_b = 1'b1; end
      S_MEM_ST:     begin w_c.mem_addr_sel = 2'd1; w_c.mem_write = 1'b1; end
      S_MEM_WAIT:   w_c.mem_addr_sel = 2'd1;
      S_MEM_WB:     begin w_c.reg_write = 1'b1; w_c.mem_to_reg = 1'b1; end
      S_MD_RUN:     w_c.md_start = (r_cnt == 6'd0);
      S_MD_WB:      w_c.hi_lo_write = 1'b1;
      S_JUMP:       begin w_c.pc_write = 1'b1; w_c.pc_src = w_jr ? 2'd2 : 2'd1; end
      S_EXC_EPC:    begin w_c.alu_op = 3'd2; w_c.alu_src_b = 1'b1; w_c.epc_write = 1'b1; end
      S_EXC_VEC_WAIT: begin
        w_c.mem_addr_sel = 2'd2;
        w_c.vec_addr     = VEC_BASE + {6'b0, r_cause};
      end
      S_EXC_LOAD_PC: begin w_c.pc_write = 1'b1; w_c.pc_src = 2'd3; end
      default: ;
    endcase
  end

  // Outputs are forced low combinationally while reset is held.
  assign w_g = reset ? w_c : '0;

  assign pc_write     = w_g.pc_write;
  assign pc_src       = w_g.pc_src;
  assign ir_write     = w_g.ir_write;
  assign mem_write    = w_g.mem_write;
  assign mem_addr_sel = w_g.mem_addr_sel;
  assign vec_addr     = w_g.vec_addr;
  assign alu_op       = w_g.alu_op;
  assign alu_src_b    = w_g.alu_src_b;
  assign reg_write    = w_g.reg_write;
  assign mem_to_reg   = w_g.mem_to_reg;
  assign sp_init      = w_g.sp_init;
  assign md_start     = w_g.md_start;
  assign hi_lo_write  = w_g.hi_lo_write;
  assign epc_write    = w_g.epc_write;
  assign exc_cause    = w_g.exc_cause;
  assign state_o      = w_g.state;

endmodule

// File: tb/tb_multicycle_ctrl_seq.sv
// Randomised bench: a per-instruction cycle trace model predicts every output
// cycle by cycle from the instruction class and the latency parameters.
module tb_multicycle_ctrl_seq;
  localparam int         LAT = 2;
  localparam int         MDC = 32;
  localparam logic [7:0] VB  = 8'd253;

  logic       clock = 1'b0, reset = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       overflow = 1'b0, div0 = 1'b0;
  logic       pc_write, ir_write, mem_write, alu_src_b, reg_write, mem_to_reg;
  logic       sp_init, md_start, hi_lo_write, epc_write;
  logic [1:0] pc_src, mem_addr_sel, exc_cause;
  logic [7:0] vec_addr;
  logic [2:0] alu_op;
  logic [3:0] state_o;

  always #5 clock = ~clock;

  multicycle_ctrl_seq #(.MEM_LAT(LAT), .MD_CYCLES(MDC), .VEC_BASE(VB)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .overflow(overflow), .div0(div0), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
    .vec_addr(vec_addr), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .sp_init(sp_init),
    .md_start(md_start), .hi_lo_write(hi_lo_write), .epc_write(epc_write),
    .exc_cause(exc_cause), .state_o(state_o)
  );

  typedef struct packed {
    logic       pcw;
    logic [1:0] pcs;
    logic       irw, mw;
    logic [1:0] mas;
    logic [7:0] va;
    logic [2:0] aop;
    logic       asb, rw, m2r, spi, mds, hlw, epcw;
    logic [1:0] cause;
  } vec_t;

  typedef enum int {K_ADD, K_SUB, K_AND, K_ADDI, K_LW, K_SW, K_MULT, K_DIV,
                    K_JR, K_J, K_BAD} kind_e;

  vec_t       q[$];
  logic [1:0] m_cause = 2'd0;
  int         total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vec_t obs();
    vec_t v;
    v = '{pc_write, pc_src, ir_write, mem_write, mem_addr_sel, vec_addr, alu_op,
          alu_src_b, reg_write, mem_to_reg, sp_init, md_start, hi_lo_write,
          epc_write, exc_cause};
    return v;
  endfunction

  function automatic vec_t base();
    vec_t v = '0;
    v.cause = m_cause;
    return v;
  endfunction

  function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      case (fn)
        6'h20: return K_ADD;
        6'h22: return K_SUB;
        6'h24: return K_AND;
        6'h18: return K_MULT;
        6'h1A: return K_DIV;
        6'h08: return K_JR;
        default: return K_BAD;
      endcase
    end
    case (op)
      6'h02: return K_J;
      6'h08: return K_ADDI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      default: return K_BAD;
    endcase
  endfunction

  task automatic exc(input logic [1:0] c);
    vec_t v;
    m_cause = c;
    v = base(); v.aop = 3'd2; v.asb = 1'b1; v.epcw = 1'b1; q.push_back(v);
    for (int i = 0; i < LAT; i++) begin
      v = base(); v.mas = 2'd2; v.va = VB + {6'b0, c}; q.push_back(v);
    end
    v = base(); v.pcw = 1'b1; v.pcs = 2'd3; q.push_back(v);
  endtask

  task automatic build(input kind_e k, input logic ov, input logic d0);
    vec_t v;
    v = base(); v.pcw = 1'b1; v.aop = 3'd1; v.asb = 1'b1; q.push_back(v);
    for (int i = 0; i < LAT; i++) begin
      v = base(); v.irw = (i == LAT - 1); q.push_back(v);
    end
    q.push_back(base());
    case (k)
      K_ADD, K_SUB, K_AND, K_ADDI: begin
        v = base();
        v.aop = (k == K_SUB) ? 3'd2 : (k == K_AND) ? 3'd3 : 3'd1;
        v.asb = (k == K_ADDI);
        q.push_back(v);
        if (ov && k != K_AND) exc(2'd1);
        else begin v = base(); v.rw = 1'b1; q.push_back(v); end
      end
      K_LW, K_SW: begin
        v = base(); v.aop = 3'd1; v.asb = 1'b1; q.push_back(v);
        if (k == K_SW) begin
          v = base(); v.mas = 2'd1; v.mw = 1'b1; q.push_back(v);
        end else begin
          for (int i = 0; i < LAT; i++) begin
            v = base(); v.mas = 2'd1; q.push_back(v);
          end
          v = base(); v.rw = 1'b1; v.m2r = 1'b1; q.push_back(v);
        end
      end
      K_MULT, K_DIV: begin
        v = base(); v.mds = 1'b1; q.push_back(v);
        if (k == K_DIV && d0) exc(2'd2);
        else begin
          for (int i = 1; i < MDC; i++) q.push_back(base());
          v = base(); v.hlw = 1'b1; q.push_back(v);
        end
      end
      K_J, K_JR: begin
        v = base(); v.pcw = 1'b1; v.pcs = (k == K_J) ? 2'd1 : 2'd2; q.push_back(v);
      end
      default: exc(2'd0);
    endcase
  endtask

  // Called at the negedge of a FETCH cycle; leaves at the next FETCH negedge,
  // or after `stop` compared cycles when stop > 0.
  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input logic ov, input logic d0, input int stop);
    kind_e k;
    int    n;
    opcode = op; funct = fn; overflow = ov; div0 = d0;
    k = classify(op, fn);
    q.delete();
    build(k, ov, d0);
    n = (stop > 0) ? stop : q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("op%02h_fn%02h_c%0d", op, fn, i), 32'(obs()), 32'(q[i]));
      @(negedge clock);
    end
  endtask

  task automatic release_reset();
    vec_t v;
    m_cause = 2'd0;
    reset = 1'b1;
    #1;
    v = base(); v.rw = 1'b1; v.spi = 1'b1;
    chk("reset_exec", 32'(obs()), 32'(v));
    @(negedge clock);
  endtask

  task automatic rand_instr();
    logic [5:0] op, fn;
    case ($urandom_range(0, 12))
      0:  begin op = 6'h00; fn = 6'h20; end
      1:  begin op = 6'h00; fn = 6'h22; end
      2:  begin op = 6'h00; fn = 6'h24; end
      3:  begin op = 6'h00; fn = 6'h18; end
      4:  begin op = 6'h00; fn = 6'h1A; end
      5:  begin op = 6'h00; fn = 6'h08; end
      6:  begin op = 6'h02; fn = 6'($urandom); end
      7:  begin op = 6'h08; fn = 6'($urandom); end
      8:  begin op = 6'h23; fn = 6'($urandom); end
      9:  begin op = 6'h2B; fn = 6'($urandom); end
      10: begin op = 6'($urandom); fn = 6'($urandom); end
      11: begin op = 6'h00; fn = 6'($urandom); end
      default: begin op = 6'h3F; fn = 6'($urandom); end
    endcase
    run(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_outs", 32'(obs()), 32'd0);
    chk("reset_state", 32'(state_o), 32'd0);
    release_reset();
    // Directed: lw, add overflow, div by zero, mult, bad opcode, edge cases
    run(6'h23, 6'h00, 1'b0, 1'b0, 0);
    run(6'h00, 6'h20, 1'b1, 1'b0, 0);
    run(6'h00, 6'h1A, 1'b0, 1'b1, 0);
    run(6'h00, 6'h18, 1'b0, 1'b1, 0);
    run(6'h3F, 6'h00, 1'b0, 1'b0, 0);
    run(6'h00, 6'h24, 1'b1, 1'b0, 0);
    run(6'h00, 6'h22, 1'b1, 1'b0, 0);
    run(6'h08, 6'h00, 1'b1, 1'b0, 0);
    run(6'h2B, 6'h00, 1'b1, 1'b1, 0);
    run(6'h02, 6'h00, 1'b0, 1'b0, 0);
    run(6'h00, 6'h08, 1'b0, 1'b0, 0);
    run(6'h00, 6'h1A, 1'b0, 1'b0, 0);
    for (int i = 0; i < 40; i++) rand_instr();
    // Reset in the 10th MD_RUN cycle: FETCH + LAT waits + DECODE + 9 MD_RUN
    run(6'h00, 6'h18, 1'b0, 1'b0, 1 + LAT + 1 + 9);
    reset = 1'b0;
    #1;
    chk("midreset_outs", 32'(obs()), 32'd0);
    chk("midreset_state", 32'(state_o), 32'd0);
    @(negedge clock);
    chk("midreset_hold", 32'(obs()), 32'd0);
    release_reset();
    run(6'h00, 6'h20, 1'b0, 1'b0, 0);
    for (int i = 0; i < 8; i++) rand_instr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
